dn_leaf_collector: RTL and testbench

Downstream stage of the distribution-network (DN) router tree.
- Captures the NUM_LANES leaf outputs of the last dn_router level once the tree latency has elapsed after a root set_en.
- Masks lanes that carry no operand.
- Buffers each captured vector in a small FIFO and hands it to the PE operand registers over a valid/ready handshake.
- Returns a credit signal so the DN sequencer never issues more vectors than the FIFO can hold.

---
 rtl/dn_pkg.sv | 34 +++
 rtl/dn_vec_fifo.sv | 57 +++++
 rtl/dn_leaf_collector.sv | 109 ++++++++++
 tb/tb_dn_leaf_collector.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dn_pkg.sv
// Shared definitions for the distribution-network datapath: default tree
// geometry and lane helpers used by the router tree and the leaf collector.
package dn_pkg;

  localparam int DN_NUM_LANES  = 8;
  localparam int DN_TREE_DEPTH = $clog2(DN_NUM_LANES);

  // Helper operands are zero-extended to these maxima by the caller.
  localparam int DN_MAX_DW    = 32;
  localparam int DN_MAX_LANES = 32;
  localparam int DN_MAX_BUS   = DN_MAX_DW * DN_MAX_LANES;
  localparam int DN_CNT_W     = 8;

  function automatic logic [DN_MAX_DW-1:0] lane_slice(
    input logic [DN_MAX_BUS-1:0] bus,
    input int                    idx,
    input int                    dw
  );
    logic [DN_MAX_DW-1:0] m;
    m = '1;
    m = m >> (DN_MAX_DW - dw);
    return DN_MAX_DW'(bus >> (idx * dw)) & m;
  endfunction

  function automatic logic [DN_CNT_W-1:0] popcount(input logic [DN_MAX_LANES-1:0] v);
    logic [DN_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < DN_MAX_LANES; i++) begin
      cnt = cnt + DN_CNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/dn_vec_fifo.sv
// Generic synchronous FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module dn_vec_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/dn_leaf_collector.sv
// Leaf-side collector of the DN router tree: tracks launched vectors through
// the tree latency, captures and masks leaf data, buffers it, returns credit.
module dn_leaf_collector
  import dn_pkg::*;
#(
  parameter int DW_DATA    = 8,
  parameter int NUM_LANES  = DN_NUM_LANES,
  parameter int TREE_DEPTH = DN_TREE_DEPTH,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           set_en,
  input  logic                           route_en,
  input  logic [NUM_LANES-1:0]           lane_mask,
  input  logic [DW_DATA*NUM_LANES-1:0]   leaf_in,
  output logic                           credit_ok,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DW_DATA*NUM_LANES-1:0]   out_data,
  output logic [NUM_LANES-1:0]           out_mask,
  output logic                           overflow
);

  localparam int BUS_W  = DW_DATA * NUM_LANES;
  localparam int FIFO_W = BUS_W + NUM_LANES;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W  = DN_CNT_W + 1;

  logic [TREE_DEPTH-1:0] dl_valid;
  logic [NUM_LANES-1:0]  dl_mask [TREE_DEPTH];

  logic                  capture;
  logic [BUS_W-1:0]      cap_data;
  logic [DN_MAX_BUS-1:0] leaf_ext;
  logic [FIFO_W-1:0]     fifo_rd;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic [DN_CNT_W-1:0]   inflight;
  logic [OCC_W-1:0]      occupancy;

  // Tag delay line mirrors the router pipeline; route_en low empties it
  // because the tree drives zeros instead of the launched vectors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dl_valid <= '0;
      for (int s = 0; s < TREE_DEPTH; s++) begin
        dl_mask[s] <= '0;
      end
    end else begin
      dl_valid[0] <= set_en & route_en;
      dl_mask[0]  <= lane_mask;
      for (int s = 1; s < TREE_DEPTH; s++) begin
        dl_valid[s] <= dl_valid[s-1] & route_en;
        dl_mask[s]  <= dl_mask[s-1];
      end
    end
  end

  assign capture  = dl_valid[TREE_DEPTH-1] & route_en;
  assign leaf_ext = DN_MAX_BUS'(leaf_in);

  always_comb begin
    cap_data = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cap_data[i*DW_DATA +: DW_DATA] = dl_mask[TREE_DEPTH-1][i]
        ? DW_DATA'(lane_slice(leaf_ext, i, DW_DATA)) : '0;
    end
  end

  // Output handshake: a beat transfers on any cycle where out_valid and
  // out_ready are both high; the head is held unchanged until then.
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  dn_vec_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (capture),
    .wr_data ({dl_mask[TREE_DEPTH-1], cap_data}),
    .pop     (pop),
    .rd_data (fifo_rd),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_data = fifo_rd[BUS_W-1:0];
  assign out_mask = fifo_rd[FIFO_W-1:BUS_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (capture && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  // Credit counts every vector still inside the tree as already buffered.
  assign inflight  = popcount(DN_MAX_LANES'(dl_valid));
  assign occupancy = OCC_W'(fifo_count) + OCC_W'(inflight);
  assign credit_ok = occupancy < OCC_W'(FIFO_DEPTH);

endmodule

// File: tb/tb_dn_leaf_collector.sv
// Directed bench for dn_leaf_collector: capture latency, masking, credit,
// overflow, route_en flush and asynchronous reset.
module tb_dn_leaf_collector;

  logic        clk;
  logic        rst_n;
  logic        set_en;
  logic        route_en;
  logic [7:0]  lane_mask;
  logic [63:0] leaf_in;
  logic        credit_ok;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [7:0]  out_mask;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  dn_leaf_collector #(
    .DW_DATA    (8),
    .NUM_LANES  (8),
    .TREE_DEPTH (3),
    .FIFO_DEPTH (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en    (set_en),
    .route_en  (route_en),
    .lane_mask (lane_mask),
    .leaf_in   (leaf_in),
    .credit_ok (credit_ok),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mask  (out_mask),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    set_en    = 1'b0;
    route_en  = 1'b1;
    lane_mask = 8'h00;
    leaf_in   = 64'h0;
    out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_valid",  64'(out_valid), 64'd0);
    chk("rst_data",   out_data,       64'd0);
    chk("rst_mask",   64'(out_mask),  64'd0);
    chk("rst_ovf",    64'(overflow),  64'd0);
    chk("rst_credit", 64'(credit_ok), 64'd1);
    rst_n = 1'b1;

    // Single vector: launch at edge t, leaf sampled at edge t+3
    set_en = 1'b1; lane_mask = 8'hFF;
    tick();
    set_en = 1'b0;
    chk("t1_credit_1inflight", 64'(credit_ok), 64'd1);
    tick();
    tick();
    chk("t1_valid_early", 64'(out_valid), 64'd0);
    leaf_in = 64'h0807060504030201;
    tick();
    chk("t1_valid",  64'(out_valid), 64'd1);
    chk("t1_data",   out_data,       64'h0807060504030201);
    chk("t1_mask",   64'(out_mask),  64'hFF);
    chk("t1_credit", 64'(credit_ok), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("t1_popped", 64'(out_valid), 64'd0);
    chk("t1_empty_data", out_data, 64'd0);

    // Masking
    leaf_in = 64'hFFFF_FFFF_FFFF_FFFF;
    set_en = 1'b1; lane_mask = 8'h0F;
    tick();
    set_en = 1'b0;
    tick();
    tick();
    chk("t2_valid_early", 64'(out_valid), 64'd0);
    tick();
    chk("t2_valid", 64'(out_valid), 64'd1);
    chk("t2_data",  out_data,       64'h0000_0000_FFFF_FFFF);
    chk("t2_mask",  64'(out_mask),  64'h0F);
    tick();
    chk("t2_popped", 64'(out_valid), 64'd0);

    // Backpressure, credit and overflow
    out_ready = 1'b0;
    set_en = 1'b1; lane_mask = 8'hFF;
    tick();
    chk("t3_credit_after1", 64'(credit_ok), 64'd1);
    tick();
    chk("t3_credit_after2", 64'(credit_ok), 64'd0);
    lane_mask = 8'hAA;
    tick();
    set_en = 1'b0;
    chk("t3_credit_after3", 64'(credit_ok), 64'd0);
    leaf_in = 64'h1111_1111_1111_1111;
    tick();
    chk("t3_valid_a", 64'(out_valid), 64'd1);
    chk("t3_data_a",  out_data,       64'h1111_1111_1111_1111);
    chk("t3_mask_a",  64'(out_mask),  64'hFF);
    leaf_in = 64'h2222_2222_2222_2222;
    tick();
    chk("t3_ovf_full", 64'(overflow),  64'd0);
    chk("t3_credit_full", 64'(credit_ok), 64'd0);
    leaf_in = 64'h3333_3333_3333_3333;
    tick();
    chk("t3_ovf_set",  64'(overflow), 64'd1);
    chk("t3_head_hold", out_data,     64'h1111_1111_1111_1111);
    tick();
    chk("t3_ovf_sticky", 64'(overflow), 64'd1);
    chk("t3_head_hold2", out_data,      64'h1111_1111_1111_1111);
    out_ready = 1'b1;
    tick();
    chk("t3_data_b", out_data,      64'h2222_2222_2222_2222);
    chk("t3_mask_b", 64'(out_mask), 64'hFF);
    tick();
    chk("t3_drained",  64'(out_valid), 64'd0);
    chk("t3_credit_back", 64'(credit_ok), 64'd1);
    chk("t3_ovf_still", 64'(overflow), 64'd1);

    // Asynchronous reset between edges with one vector buffered and one in flight
    out_ready = 1'b0;
    set_en = 1'b1; lane_mask = 8'hFF;
    tick();
    set_en = 1'b0;
    tick();
    tick();
    leaf_in = 64'h7777_7777_7777_7777;
    tick();
    chk("t4_valid_before", 64'(out_valid), 64'd1);
    set_en = 1'b1;
    tick();
    set_en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_valid",  64'(out_valid), 64'd0);
    chk("t4_rst_data",   out_data,       64'd0);
    chk("t4_rst_ovf",    64'(overflow),  64'd0);
    chk("t4_rst_credit", 64'(credit_ok), 64'd1);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_no_stale", 64'(out_valid), 64'd0);
    end

    // Full FIFO with a same-cycle pop must not flag overflow
    set_en = 1'b1; lane_mask = 8'hFF;
    tick();
    tick();
    lane_mask = 8'hF0;
    tick();
    set_en = 1'b0;
    leaf_in = 64'h4444_4444_4444_4444;
    tick();
    leaf_in = 64'h5555_5555_5555_5555;
    tick();
    chk("t5_full_credit", 64'(credit_ok), 64'd0);
    chk("t5_head_a",      out_data,       64'h4444_4444_4444_4444);
    leaf_in = 64'h6666_6666_6666_6666;
    out_ready = 1'b1;
    tick();
    chk("t5_no_ovf",  64'(overflow),  64'd0);
    chk("t5_valid",   64'(out_valid), 64'd1);
    chk("t5_head_b",  out_data,       64'h5555_5555_5555_5555);
    chk("t5_credit",  64'(credit_ok), 64'd0);
    tick();
    chk("t5_head_c",  out_data,       64'h6666_6666_0000_0000);
    chk("t5_mask_c",  64'(out_mask),  64'hF0);
    tick();
    chk("t5_drained", 64'(out_valid), 64'd0);
    chk("t5_no_ovf2", 64'(overflow),  64'd0);

    // route_en flush: two in flight, then route_en low with a set_en that must be ignored
    set_en = 1'b1; lane_mask = 8'hFF;
    tick();
    tick();
    chk("t6_credit_pre", 64'(credit_ok), 64'd0);
    route_en = 1'b0;
    tick();
    chk("t6_credit_post", 64'(credit_ok), 64'd1);
    route_en = 1'b1;
    set_en = 1'b0;
    leaf_in = 64'h9999_9999_9999_9999;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_no_capture", 64'(out_valid), 64'd0);
    end
    chk("t6_credit_idle", 64'(credit_ok), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
